rsa_modexp: RTL and testbench

RSA_MODEXP -- requirements
Module: rsa_modexp

---
 rtl/rsa_pkg.sv | 14 +
 rtl/rsa_modmul.sv | 71 +++++++
 rtl/rsa_modexp.sv | 133 +++++++++++++
 tb/tb_rsa_modexp.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation slice:
// default operand width and the exponentiation FSM state encoding.
package rsa_pkg;

  localparam int DEFAULT_WIDTH = 1024;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SQUARE = 3'd2;
  localparam logic [2:0] ST_MULT   = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, one bit of a per
// cycle MSB first; rdy pulses WIDTH cycles after go. Requires b < n.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             rdy
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH+1:0] acc, acc_nx, prev, addend, nn, t0, t1;
  logic [WIDTH-1:0] a_sh, b_q, n_q, bsel, nsel;
  logic [CW-1:0]    cnt;
  logic             run, bit_i;

  // The go cycle already performs the first iteration straight from the
  // input operands, so WIDTH iterations finish exactly WIDTH cycles later.
  always_comb begin
    prev   = go ? '0 : acc;
    bit_i  = go ? a[WIDTH-1] : a_sh[WIDTH-1];
    bsel   = go ? b : b_q;
    nsel   = go ? n : n_q;
    addend = bit_i ? {2'b00, bsel} : '0;
    nn     = {2'b00, nsel};
    t0     = (prev << 1) + addend;
    t1     = (t0 >= nn) ? t0 - nn : t0;
    acc_nx = (t1 >= nn) ? t1 - nn : t1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      a_sh <= '0;
      b_q  <= '0;
      n_q  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      rdy  <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (go) begin
        acc  <= acc_nx;
        a_sh <= {a[WIDTH-2:0], 1'b0};
        b_q  <= b;
        n_q  <= n;
        cnt  <= CW'(WIDTH - 1);
        run  <= 1'b1;
      end else if (run) begin
        acc  <= acc_nx;
        a_sh <= {a_sh[WIDTH-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run <= 1'b0;
          rdy <= 1'b1;
        end
      end
    end
  end

  assign p = acc[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp.sv
// RSA decryption core: m = c^d mod n by left-to-right binary exponentiation
// over all WIDTH exponent bits, sharing one interleaved modular multiplier.
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] prime_num,
  input  logic [WIDTH-1:0] private_key,
  input  logic [WIDTH-1:0] cipher,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] m,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2:0]       state;
  logic [WIDTH-1:0] n_q, d_q, c_q, r_init, op_a, op_b, p;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             op_err, go, mul_rdy;

  always_comb begin
    r_init    = '0;
    r_init[0] = (n_q != WIDTH'(1));
    op_err    = (n_q == '0) || (c_q >= n_q);
  end

  // The accumulator R lives in the multiplier result register between steps.
  // Each next multiply is launched in the cycle the previous one reports rdy
  // (first MULT cycle or NEXT), so the state sequence adds no idle cycles.
  always_comb begin
    go   = 1'b0;
    op_a = p;
    op_b = p;
    case (state)
      ST_LOAD: begin
        go   = !op_err;
        op_a = r_init;
        op_b = r_init;
      end
      ST_MULT: begin
        go   = mul_rdy;
        op_b = c_q;
      end
      ST_NEXT: go = (idx != '0);
      default: go = 1'b0;
    endcase
  end

  rsa_modmul #(.WIDTH(WIDTH)) u_mul (
    .clk (clk),
    .rst (rst),
    .go  (go),
    .a   (op_a),
    .b   (op_b),
    .n   (n_q),
    .p   (p),
    .rdy (mul_rdy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      n_q   <= '0;
      d_q   <= '0;
      c_q   <= '0;
      idx   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      m     <= '0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_q   <= prime_num;
            d_q   <= private_key;
            c_q   <= cipher;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          idx <= IW'(WIDTH - 1);
          cnt <= CW'(WIDTH - 2);
          if (op_err) begin
            m     <= '0;
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_SQUARE;
          end
        end
        ST_SQUARE: begin
          if (cnt == '0) state <= d_q[idx] ? ST_MULT : ST_NEXT;
          else           cnt   <= cnt - 1'b1;
        end
        ST_MULT: begin
          if (mul_rdy)         cnt   <= CW'(WIDTH - 2);
          else if (cnt == '0)  state <= ST_NEXT;
          else                 cnt   <= cnt - 1'b1;
        end
        ST_NEXT: begin
          if (idx == '0) begin
            m     <= p;
            err   <= 1'b0;
            state <= ST_DONE;
          end else begin
            idx   <= idx - 1'b1;
            cnt   <= CW'(WIDTH - 2);
            state <= ST_SQUARE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp: plain-arithmetic exponentiation model,
// per-cycle output monitor, directed cases plus randomized operands.
module tb_rsa_modexp;

  logic        clk, rst, start, busy, done, err;
  logic [15:0] prime_num, private_key, cipher, m;

  logic          big_start, big_busy, big_done, big_err;
  logic [1023:0] big_n, big_d, big_c, big_m;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  bit          armed = 0;
  logic [15:0] exp_m;
  bit          exp_err;
  int          exp_lat;

  rsa_modexp #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .prime_num(prime_num),
    .private_key(private_key), .cipher(cipher),
    .busy(busy), .done(done), .m(m), .err(err)
  );

  rsa_modexp #(.WIDTH(1024)) dut_big (
    .clk(clk), .rst(rst), .start(big_start), .prime_num(big_n),
    .private_key(big_d), .cipher(big_c),
    .busy(big_busy), .done(big_done), .m(big_m), .err(big_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // m = c^d mod n with every exponent bit visited; latency from the rules.
  function automatic void model(input logic [15:0] n, input logic [15:0] d,
                                input logic [15:0] c, output logic [15:0] mm,
                                output bit e, output int lat);
    longint unsigned r;
    int pc;
    if (n == 0 || c >= n) begin
      mm = 0; e = 1; lat = 2;
      return;
    end
    r  = (n == 1) ? 0 : 1;
    pc = 0;
    for (int i = 15; i >= 0; i--) begin
      r = (r * r) % n;
      if (d[i]) begin
        r = (r * c) % n;
        pc++;
      end
    end
    mm = 16'(r); e = 0; lat = 2 + 16 * (16 + pc);
  endfunction

  always @(posedge clk) if (armed) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (armed) begin
        if (done) begin
          check("done_latency", cyc, exp_lat);
          check("m", m, exp_m);
          check("err", err, exp_err);
          check("busy_at_done", busy, 0);
          armed = 0;
          done_cnt++;
        end else begin
          check("busy_while_running", busy, 1);
        end
      end else begin
        check("no_done_when_idle", done, 0);
        if (done) done_cnt++;
      end
    end
  end

  task automatic start_op(input logic [15:0] n, input logic [15:0] d,
                          input logic [15:0] c, input bit now);
    model(n, d, c, exp_m, exp_err, exp_lat);
    if (!now) begin
      @(posedge clk); #1;
    end
    prime_num = n; private_key = d; cipher = c; start = 1;
    @(posedge clk); #1;
    start = 0; cyc = 0; armed = 1;
  endtask

  task automatic wait_done();
    for (int k = 0; k < exp_lat + 20; k++) begin
      if (!armed) break;
      @(posedge clk);
    end
    #2;
    check("completed_in_budget", armed, 0);
    armed = 0;
  endtask

  initial begin
    logic [15:0] pm, rn, rd, rc;
    bit          pe;
    int          pl, base;

    rst = 1; start = 0; prime_num = 0; private_key = 0; cipher = 0;
    big_start = 0; big_n = '0; big_d = '0; big_c = '0;

    model(16'd3233, 16'd2753, 16'd2790, pm, pe, pl);
    check("model_pin_m", pm, 65);
    check("model_pin_lat", pl, 338);
    model(16'd3233, 16'd0, 16'd1234, pm, pe, pl);
    check("model_pin_d0_lat", pl, 258);

    #3;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_m", m, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // start in the very first cycle after reset release
    start_op(16'd3233, 16'd2753, 16'd2790, 1);
    wait_done();
    check("rsa_m_literal", m, 65);

    start_op(16'd3233, 16'd0, 16'd1234, 0);
    wait_done();
    check("d0_m_literal", m, 1);
    start_op(16'd1, 16'd0, 16'd0, 0);
    wait_done();
    check("n1_m_literal", m, 0);
    start_op(16'd1, 16'd40000, 16'd0, 0);
    wait_done();

    start_op(16'd3233, 16'd2753, 16'd2790, 0);
    wait_done();
    start_op(16'd3233, 16'd2753, 16'd3233, 0);
    wait_done();
    check("c_eq_n_err_literal", err, 1);
    check("c_eq_n_m_literal", m, 0);
    start_op(16'd0, 16'd5, 16'd7, 0);
    wait_done();
    check("n0_err_literal", err, 1);

    // start again mid-run with different operands: must be ignored
    base = done_cnt;
    start_op(16'd3233, 16'd2753, 16'd2790, 0);
    repeat (50) @(posedge clk);
    #1 prime_num = 16'd1000; private_key = 16'd5; cipher = 16'd7; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done();
    repeat (20) @(posedge clk);
    check("restart_ignored_one_done", done_cnt, base + 1);
    check("restart_ignored_m", m, 65);

    // reset at cycle 100 of a run
    start_op(16'd3233, 16'd2753, 16'd2790, 0);
    repeat (100) @(posedge clk);
    #2 armed = 0; rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_m", m, 0);
    check("abort_done", done, 0);
    @(posedge clk); #1 rst = 0;
    base = done_cnt;
    repeat (600) @(posedge clk);
    check("abort_no_done", done_cnt, base);
    start_op(16'd3233, 16'd2753, 16'd2790, 0);
    wait_done();
    check("after_abort_m", m, 65);

    for (int t = 0; t < 8; t++) begin
      rn = 16'($urandom_range(2, 50000));
      rd = 16'($urandom);
      rc = 16'($urandom_range(0, 32'(rn) + 32'(rn) / 8));
      start_op(rn, rd, rc, 0);
      wait_done();
    end

    // wide instance: c >= n must be flagged two cycles after start
    big_n = 1024'h100; big_d = 1024'h20; big_c = 1024'h200;
    @(posedge clk); #1 big_start = 1;
    @(posedge clk); #1 big_start = 0;
    @(posedge clk); #1;
    check("big_done_early", big_done, 0);
    check("big_busy", big_busy, 1);
    @(posedge clk); #1;
    check("big_done", big_done, 1);
    check("big_err", big_err, 1);
    check("big_m_nonzero", longint'(big_m != '0), 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
